// File: rtl/calc_pkg.sv
// Shared widths, operand limits, opcode/state encodings and range helper
// for the calculator execution core.
package calc_pkg;
  localparam int OPW  = 8;
  localparam int RESW = 2 * OPW;
  localparam int CNTW = $clog2(OPW);

  localparam logic signed [RESW-1:0] OPND_MIN = RESW'(-(2 ** (OPW - 1)));
  localparam logic signed [RESW-1:0] OPND_MAX = RESW'(2 ** (OPW - 1) - 1);

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_B, ST_EXEC, ST_FIX} state_t;

  function automatic logic in_range(input logic signed [RESW-1:0] v);
    return (v >= OPND_MIN) && (v <= OPND_MAX);
  endfunction
endpackage

// File: rtl/calc_exec_unit_muldiv.sv
// Iterative unsigned OPW x OPW shift-add multiply and OPW/OPW restoring divide.
// Loads on start, then one step per cycle; done is high during the last step.
module seq_muldiv
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  op_t             op,
  input  logic [OPW-1:0]  a_mag,
  input  logic [OPW-1:0]  b_mag,
  input  logic [CNTW-1:0] step,
  output logic            done,
  output logic [RESW-1:0] product,
  output logic [OPW-1:0]  quotient,
  output logic [OPW-1:0]  remainder
);
  logic            run;
  logic            is_div;
  logic [RESW-1:0] acc;
  logic [OPW-1:0]  dsr;
  logic [OPW-1:0]  rem;
  logic [OPW:0]    msum;
  logic [OPW:0]    dsh;
  logic            dfit;

  // Multiply keeps the multiplier in the low half of acc; divide keeps the
  // dividend there and shifts quotient bits in behind it.
  assign msum = {1'b0, acc[RESW-1:OPW]} + (acc[0] ? {1'b0, dsr} : '0);
  assign dsh  = {rem, acc[OPW-1]};
  assign dfit = (dsh >= {1'b0, dsr});
  assign done = run && (step == CNTW'(OPW - 1));

  assign product   = acc;
  assign quotient  = acc[OPW-1:0];
  assign remainder = rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      is_div <= 1'b0;
      acc    <= '0;
      dsr    <= '0;
      rem    <= '0;
    end else if (start) begin
      run    <= 1'b1;
      is_div <= (op == OP_DIV);
      acc    <= {{OPW{1'b0}}, (op == OP_DIV) ? a_mag : b_mag};
      dsr    <= (op == OP_DIV) ? b_mag : a_mag;
      rem    <= '0;
    end else if (run) begin
      if (done) run <= 1'b0;
      if (is_div) begin
        acc[OPW-1:0] <= {acc[OPW-2:0], dfit};
        rem          <= dfit ? OPW'(dsh - {1'b0, dsr}) : dsh[OPW-1:0];
      end else begin
        acc <= {msum, acc[OPW-1:1]};
      end
    end
  end
endmodule

// File: rtl/calc_exec_unit.sv
// Calculator execution core: edge-detects keys, captures A/B, runs add/sub in
// 1 cycle or mul/div over OPW steps plus a sign-fix cycle; no input backpressure.
module calc_exec_unit
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RESW-1:0] operand,
  input  logic            add,
  input  logic            sub,
  input  logic            mult,
  input  logic            div,
  input  logic            start,
  output logic [RESW-1:0] result,
  output logic [OPW-1:0]  remainder,
  output logic            busy,
  output logic            done,
  output logic            error
);
  state_t          state;
  op_t             op_q;
  op_t             op_sel;
  logic [4:0]      keys, key_q, ev;
  logic            op_ev;
  logic [OPW-1:0]  a_q, b_q, a_mag, b_mag;
  logic            a_err_q, fail_q, b_fail, md_start, md_done, neg;
  logic [CNTW-1:0] cnt;
  logic [RESW-1:0] a_ext, b_ext, md_prod, quot_ext;
  logic [OPW-1:0]  md_quot, md_rem;

  assign keys = {start, div, mult, sub, add};
  assign ev   = keys & ~key_q;

  always_comb begin
    op_ev  = |ev[3:0];
    op_sel = OP_DIV;
    if (ev[0])      op_sel = OP_ADD;
    else if (ev[1]) op_sel = OP_SUB;
    else if (ev[2]) op_sel = OP_MUL;
  end

  // B is evaluated straight off the operand bus in the cycle Start is taken.
  assign b_fail   = a_err_q | ~in_range(operand) | ((op_q == OP_DIV) && (operand == '0));
  assign md_start = (state == ST_WAIT_B) && !op_ev && ev[4] && !b_fail &&
                    ((op_q == OP_MUL) || (op_q == OP_DIV));
  assign a_mag    = a_q[OPW-1] ? -a_q : a_q;
  assign b_mag    = operand[OPW-1] ? -operand[OPW-1:0] : operand[OPW-1:0];
  assign a_ext    = {{OPW{a_q[OPW-1]}}, a_q};
  assign b_ext    = {{OPW{b_q[OPW-1]}}, b_q};
  assign neg      = a_q[OPW-1] ^ b_q[OPW-1];
  assign quot_ext = {{OPW{1'b0}}, md_quot};

  seq_muldiv u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_start),
    .op        (op_q),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .step      (cnt),
    .done      (md_done),
    .product   (md_prod),
    .quotient  (md_quot),
    .remainder (md_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE; op_q <= OP_ADD; key_q <= '0;
      a_q <= '0; b_q <= '0; a_err_q <= 1'b0; fail_q <= 1'b0; cnt <= '0;
      result <= '0; remainder <= '0; busy <= 1'b0; done <= 1'b0; error <= 1'b0;
    end else begin
      key_q <= keys;
      done  <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        ST_IDLE, ST_WAIT_B: begin
          if (op_ev) begin
            a_q     <= operand[OPW-1:0];
            a_err_q <= ~in_range(operand);
            op_q    <= op_sel;
            state   <= ST_WAIT_B;
          end else if (ev[4] && (state == ST_WAIT_B)) begin
            b_q    <= operand[OPW-1:0];
            fail_q <= b_fail;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cnt <= cnt + 1'b1;
          if (fail_q || (op_q == OP_ADD) || (op_q == OP_SUB)) begin
            result    <= fail_q ? '0 : ((op_q == OP_ADD) ? a_ext + b_ext : a_ext - b_ext);
            remainder <= '0;
            error     <= fail_q;
            done      <= 1'b1;
            state     <= ST_IDLE;
          end else if (md_done) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (op_q == OP_MUL) begin
            result    <= neg ? -md_prod : md_prod;
            remainder <= '0;
          end else begin
            result    <= neg ? -quot_ext : quot_ext;
            remainder <= a_q[OPW-1] ? -md_rem : md_rem;
          end
          error <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/calc_exec_unit.md
# calc_exec_unit

Sequential arithmetic core of the eight-bit four-function calculator, directly downstream of the input unit. Consumes the input unit's level-held operator/start flags and its 16-bit two's-complement operand. Captures operand A on an operator key and operand B on Start, then executes add, subtract, shift-add multiply or restoring divide. Drives a signed 16-bit result, remainder and status to the display stage.

## Interface
- OPW, 8: operand width in bits; signed range -2^(OPW-1)..2^(OPW-1)-1.
- RESW, 16: result width (2*OPW).

- Clock  in  1  system clock; all state on rising edge.
- Clear  in  1  asynchronous, active-low reset.
- Operand  in  16  two's-complement value from input unit, valid whenever sampled.
- Add, Sub, Mult, Div  in  1 each  level flags from input unit, held until next key.
- Start  in  1  level flag ("=" key), held until next key.
- Result  out  RESW  signed result; quotient for Div.
- Remainder  out  OPW  signed remainder for Div, else 0.
- Busy  out  1  high in EXEC and FIX.
- Done  out  1  one-cycle pulse when Result/Remainder/Error update.
- Error  out  1  sticky until next completion: divide-by-zero or operand out of range.

## Operation
- Edge detect: each of Add/Sub/Mult/Div/Start is registered; an event is input high this cycle while its registered copy is low. A level held for N cycles yields exactly one event.
- States: IDLE, WAIT_B, EXEC, FIX.
- IDLE or WAIT_B, operator event: latch A = Operand[OPW-1:0] and the opcode, record range flag for A, go to WAIT_B. In WAIT_B this replaces both A and opcode.
- Simultaneous operator events: priority Add > Sub > Mult > Div.
- Start event in IDLE: ignored. Start event in WAIT_B: latch B and its range flag, go to EXEC.
- Operator and Start events in the same cycle: the operator is taken and Start is ignored.
- Range check: Operand outside -128..127 sets the error condition for that operand.
- Add/Sub: EXEC lasts 1 cycle. Computes sign-extended A±B into Result, then goes to IDLE.
- Mult: |A|·|B| by 8-step shift-add, 1 step per EXEC cycle. FIX applies the sign (A xor B).
- Div: 8-step restoring division on magnitudes. Quotient truncates toward zero and its sign is A xor B. Remainder takes the sign of A. Example: -128/-1 = +128.
- Error completion:
  - B = 0 for Div: Error=1, Result=0, Remainder=0. Completes in 1 EXEC cycle, no iteration.
  - Either operand out of range: Error=1, Result=0, Remainder=0, 1 cycle.
- Events arriving in EXEC/FIX are discarded; edge history still updates, so a key held across completion does not retrigger.
- Result/Remainder/Error hold until the next completion or Clear.
- Clear low at any time: state IDLE, edge registers 0, all outputs 0, iteration abandoned.

## Timing
- Start event sampled at edge k.
- Add/Sub/error: Result valid and Done=1 after edge k+1; IDLE after k+1.
- Mult/Div: EXEC over edges k+1..k+8, FIX at k+9. Result valid and Done=1 after edge k+9.
- Busy=1 from after edge k through the cycle in which Done is high; Busy=0 after the next edge.
- Throughput: one operation per operand/Start sequence; no queuing.
- Reset values: Result 0, Remainder 0, Busy 0, Done 0, Error 0.

## Structure
- Package calc_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
  - state_t enum.
  - OPW/RESW defaults and operand min/max constants.
- Sub-module seq_muldiv:
  - Iterative unsigned 8×8 multiply and 8/8 restoring divide.
  - Ports: start, op, a_mag, b_mag, step counter, done, product/quotient/remainder.
  - calc_exec_unit keeps edge detection, FSM, range/sign handling and output registers.

## Test plan
- Operand=25 with Add held 5 cycles, then Operand=-7 with Start held 5 cycles → Result=18 (0x0012), Done once after k+1, no second Done.
- A=-12, Mult, B=11, Start → Busy for 10 cycles, Result=0xFF7C (-132), Done after edge k+9.
- A=-100, Div, B=7 → Result=-14 (0xFFF2), Remainder=-2 (0xFE), Error=0. A=-128, B=-1 → Result=128.
- A=50, Div, B=0 → Error=1, Result=0, Done after k+1. A=200, Add, B=1 → Error=1, Result=0.
- Clear driven low during the 4th EXEC cycle of Mult → all outputs 0 immediately. After release, Start alone is ignored (IDLE).
- Sub event in WAIT_B then Add event with new Operand → Add executes on the new A. Start in IDLE → no Done.
